enc_period_meter: RTL and testbench

- Measures the time between successive quadrature count changes from the encoder counter stage, for feed-rate and stall supervision.
- Consumes that stage's enc_changed pulse, bidir_counter and error outputs.
- Produces a block-averaged period in clock cycles, a movement direction and a stopped/timeout indication for the motion controller and its register readout.

---
 rtl/enc_period_meter.sv | 134 +++++++++++++
 tb/tb_enc_period_meter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/enc_period_meter.sv
// enc_period_meter: block-averaged interval between encoder count changes, with direction and standstill detection
// Ports:
//   clock, reset_n                 clock and asynchronous active-low reset
//   sclr, ena                      synchronous clear; enable (low clears all but err_flag)
//   enc_changed, bidir_counter     count-change pulse and the new signed count
//   enc_error, err_clr             sequence error input; clear for the sticky err_flag
//   period, period_valid           averaged interval in cycles (all-ones when not valid)
//   period_upd                     one-cycle pulse when period is written
//   dir, stopped, err_flag         direction of last edge, standstill, sticky error
module enc_period_meter #(
   parameter int CNT_W    = 32,
   parameter int AVG_LOG2 = 2,
   parameter int TIMEOUT  = 50000000
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               sclr,
   input  logic               ena,
   input  logic               enc_changed,
   input  logic signed [31:0] bidir_counter,
   input  logic               enc_error,
   input  logic               err_clr,
   output logic [CNT_W-1:0]   period,
   output logic               period_valid,
   output logic               period_upd,
   output logic               dir,
   output logic               stopped,
   output logic               err_flag
);
   localparam int AW = CNT_W + AVG_LOG2;
   localparam int NW = AVG_LOG2 + 1;
   localparam logic [NW-1:0]    N_MAX = NW'(1 << AVG_LOG2);
   localparam logic [CNT_W-1:0] T_MAX = CNT_W'(TIMEOUT);
   typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
   state_t             state, state_nx;
   logic [CNT_W-1:0]   timer, timer_nx, period_nx;
   logic [AW-1:0]      acc, acc_nx, interval, acc_sum;
   logic [NW-1:0]      n, n_nx, n_inc;
   logic signed [31:0] last_pos, last_nx;
   logic               valid_nx, upd_nx, dir_nx, stopped_nx, err_nx;
   logic               clr, edge_ok, edge_dir;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         timer        <= '0;
         acc          <= '0;
         n            <= '0;
         last_pos     <= '0;
         period       <= '1;
         period_valid <= 1'b0;
         period_upd   <= 1'b0;
         dir          <= 1'b0;
         stopped      <= 1'b1;
         err_flag     <= 1'b0;
      end else begin
         state        <= state_nx;
         timer        <= timer_nx;
         acc          <= acc_nx;
         n            <= n_nx;
         last_pos     <= last_nx;
         period       <= period_nx;
         period_valid <= valid_nx;
         period_upd   <= upd_nx;
         dir          <= dir_nx;
         stopped      <= stopped_nx;
         err_flag     <= err_nx;
      end
   end
   always_comb begin
      clr      = sclr | ~ena | enc_error;
      // an edge that does not change the count is ignored entirely
      edge_ok  = enc_changed & ~clr & (bidir_counter != last_pos);
      edge_dir = bidir_counter > last_pos;
      interval = AW'(timer) + AW'(1);
      // ARMED starts a fresh block, RUN extends the current one
      n_inc    = (state == ARMED) ? NW'(1) : n + NW'(1);
      acc_sum  = ((state == ARMED) ? '0 : acc) + interval;
      state_nx   = state;
      timer_nx   = edge_ok ? '0 : (timer == T_MAX) ? timer : timer + CNT_W'(1);
      acc_nx     = acc;
      n_nx       = n;
      last_nx    = edge_ok ? bidir_counter : last_pos;
      period_nx  = period;
      valid_nx   = period_valid;
      upd_nx     = 1'b0;
      dir_nx     = edge_ok ? edge_dir : dir;
      stopped_nx = stopped;
      err_nx     = sclr ? 1'b0 : enc_error ? 1'b1 : err_clr ? 1'b0 : err_flag;
      if (clr) begin
         state_nx   = IDLE;
         timer_nx   = '0;
         acc_nx     = '0;
         n_nx       = '0;
         last_nx    = '0;
         period_nx  = '1;
         valid_nx   = 1'b0;
         dir_nx     = 1'b0;
         stopped_nx = 1'b1;
      end else if (edge_ok) begin
         if (state == IDLE) begin
            state_nx = ARMED;
         end else if (edge_dir != dir) begin
            // reversal: the reference edge restarts, any partial block is dropped
            if (state == RUN) begin
               state_nx  = ARMED;
               acc_nx    = '0;
               n_nx      = '0;
               valid_nx  = 1'b0;
               period_nx = '1;
            end
         end else begin
            state_nx   = RUN;
            stopped_nx = 1'b0;
            if (n_inc == N_MAX) begin
               period_nx = CNT_W'(acc_sum >> AVG_LOG2);
               upd_nx    = 1'b1;
               valid_nx  = 1'b1;
               acc_nx    = '0;
               n_nx      = '0;
            end else begin
               acc_nx = acc_sum;
               n_nx   = n_inc;
            end
         end
      end else if (state != IDLE && timer == T_MAX) begin
         state_nx   = IDLE;
         stopped_nx = 1'b1;
         valid_nx   = 1'b0;
         period_nx  = '1;
         acc_nx     = '0;
         n_nx       = '0;
      end
   end
endmodule

// File: tb/tb_enc_period_meter.sv
// tb_enc_period_meter: directed checks of averaging, reversal, timeout, error and reset behaviour
module tb_enc_period_meter;
   localparam logic [31:0] ONES = 32'hFFFF_FFFF;
   logic               clock = 1'b0;
   logic               reset_n = 1'b0;
   logic               sclr = 1'b0;
   logic               ena = 1'b1;
   logic               enc_changed = 1'b0;
   logic signed [31:0] bidir_counter = '0;
   logic               enc_error = 1'b0;
   logic               err_clr = 1'b0;
   logic [31:0]        period;
   logic               period_valid, period_upd, dir, stopped, err_flag;
   int                 total = 0;
   int                 bad = 0;
   enc_period_meter #(.CNT_W(32), .AVG_LOG2(2), .TIMEOUT(1000)) dut (
      .clock(clock), .reset_n(reset_n), .sclr(sclr), .ena(ena),
      .enc_changed(enc_changed), .bidir_counter(bidir_counter),
      .enc_error(enc_error), .err_clr(err_clr),
      .period(period), .period_valid(period_valid), .period_upd(period_upd),
      .dir(dir), .stopped(stopped), .err_flag(err_flag)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic idle(input int k);
      repeat (k) tick();
   endtask
   task automatic pulse(input int p);
      enc_changed = 1'b1;
      bidir_counter = p;
      tick();
      enc_changed = 1'b0;
   endtask
   task automatic step(input int p, input int g);
      idle(g - 1);
      pulse(p);
   endtask
   task automatic clear();
      sclr = 1'b1;
      tick();
      sclr = 1'b0;
   endtask
   initial begin
      idle(2);
      chk("rst_period", period, ONES);
      chk("rst_valid", period_valid, 0);
      chk("rst_upd", period_upd, 0);
      chk("rst_dir", dir, 0);
      chk("rst_stopped", stopped, 1);
      chk("rst_err", err_flag, 0);
      reset_n = 1'b1;
      idle(2);
      // steady motion, +1 every 10 cycles
      pulse(1);
      chk("arm_stopped", stopped, 1);
      step(2, 10);
      chk("run_stopped", stopped, 0);
      chk("run_valid", period_valid, 0);
      step(3, 10);
      step(4, 10);
      chk("pre_upd", period_upd, 0);
      step(5, 10);
      chk("upd1", period_upd, 1);
      chk("period1", period, 10);
      chk("valid1", period_valid, 1);
      chk("dir1", dir, 1);
      tick();
      chk("upd1_drop", period_upd, 0);
      idle(8);
      pulse(6);
      step(7, 10);
      step(8, 10);
      chk("upd2_early", period_upd, 0);
      step(9, 10);
      chk("upd2", period_upd, 1);
      chk("period2", period, 10);
      // uneven intervals, then truncating average
      clear();
      chk("sclr_period", period, ONES);
      chk("sclr_stopped", stopped, 1);
      pulse(50);
      step(51, 8);
      step(52, 12);
      step(53, 9);
      step(54, 11);
      chk("uneven_upd", period_upd, 1);
      chk("uneven_period", period, 10);
      step(55, 20);
      step(56, 21);
      step(57, 22);
      step(58, 23);
      chk("trunc_period", period, 21);
      // reversal during RUN
      clear();
      pulse(96);
      step(97, 10);
      step(98, 10);
      step(99, 10);
      step(100, 10);
      chk("rev_pre_valid", period_valid, 1);
      step(101, 10);
      step(100, 10);
      chk("rev_dir", dir, 0);
      chk("rev_valid", period_valid, 0);
      chk("rev_period", period, ONES);
      chk("rev_stopped", stopped, 0);
      chk("rev_upd", period_upd, 0);
      step(99, 10);
      chk("rev_run_upd", period_upd, 0);
      step(98, 7);
      step(97, 7);
      step(96, 7);
      chk("rev_avg_upd", period_upd, 1);
      chk("rev_avg_period", period, 7);
      chk("rev_avg_dir", dir, 0);
      // timeout
      idle(1000);
      chk("to_not_yet", stopped, 0);
      chk("to_not_yet_valid", period_valid, 1);
      tick();
      chk("to_stopped", stopped, 1);
      chk("to_valid", period_valid, 0);
      chk("to_period", period, ONES);
      // edge exactly at timer==TIMEOUT wins, interval 1001, then three interval-1 edges
      pulse(95);
      chk("col_arm_dir", dir, 0);
      idle(1000);
      pulse(94);
      chk("col_stopped", stopped, 0);
      pulse(93);
      pulse(92);
      pulse(91);
      chk("col_upd", period_upd, 1);
      chk("col_period", period, 251);
      // error handling
      enc_error = 1'b1;
      tick();
      enc_error = 1'b0;
      chk("err_set", err_flag, 1);
      chk("err_stopped", stopped, 1);
      chk("err_period", period, ONES);
      chk("err_valid", period_valid, 0);
      pulse(5);
      chk("err_idle", stopped, 1);
      step(6, 10);
      chk("err_rearm", stopped, 0);
      enc_error = 1'b1;
      err_clr = 1'b1;
      tick();
      enc_error = 1'b0;
      err_clr = 1'b0;
      chk("err_set_wins", err_flag, 1);
      ena = 1'b0;
      tick();
      ena = 1'b1;
      chk("ena_keeps_err", err_flag, 1);
      chk("ena_stopped", stopped, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_clr", err_flag, 0);
      enc_error = 1'b1;
      tick();
      enc_error = 1'b0;
      chk("err_set2", err_flag, 1);
      clear();
      chk("sclr_err", err_flag, 0);
      // asynchronous reset mid-RUN
      pulse(10);
      step(11, 10);
      step(12, 10);
      step(13, 10);
      step(14, 10);
      chk("ar_pre_valid", period_valid, 1);
      step(15, 10);
      step(16, 10);
      idle(3);
      #3 reset_n = 1'b0;
      #1;
      chk("ar_period", period, ONES);
      chk("ar_valid", period_valid, 0);
      chk("ar_stopped", stopped, 1);
      chk("ar_dir", dir, 0);
      chk("ar_upd", period_upd, 0);
      tick();
      chk("ar_upd_hold", period_upd, 0);
      reset_n = 1'b1;
      tick();
      chk("ar_upd_after", period_upd, 0);
      pulse(17);
      chk("ar_idle", stopped, 1);
      chk("ar_no_upd", period_upd, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
